// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding and the largest supported requester count.
package uart_arb_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] LOCK_ENC = 2'd1;
  localparam logic [1:0] SEND_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE_ENC,
    ST_LOCK = LOCK_ENC,
    ST_SEND = SEND_ENC
  } state_t;

  localparam int NREQ_MAX = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take the grant.
// Ports: req (N requests), ptr (highest-priority index), gnt (one-hot, 0 if no request).
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ byte streams; round-robin with packet lock.
// Latency: 1 cycle arbitration, byte accepted in LOCK appears on tx_valid next cycle.
// Backpressure: a byte is held on tx_data until tx_ready; only then is the owner offered req_ready again.
// Ports: clk, rst_n (async active-low); req_valid/req_data/req_last/req_ready per requester
//        (byte i at req_data[8*i+7:8*i]); tx_data/tx_valid/tx_ready towards uart_tx;
//        grant (one-hot owner), busy (not idle), timeout (forced-release pulse).
// Option: define UART_ARB_TIMEOUT_EN to release an owner that stalls in LOCK for TIMEOUT cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT < 2) begin : g_bad_param
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT >= 2");
  end

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [7:0]      tx_data_d;
  logic            tx_valid_d;
  logic            last_q, last_d;
  logic            busy_d;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   g_idx;
  logic [PW-1:0]   ptr_inc;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            expire;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Binary index of the current owner, used for data muxing and pointer advance.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) g_idx = PW'(i);
    end
  end

  assign sel_valid = |(req_valid & grant);
  assign sel_last  = |(req_last & grant);
  assign sel_data  = req_data[{g_idx, 3'b000} +: 8];
  // The requester after the owner gets top priority next time round.
  assign ptr_inc   = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Only a LOCK-state stall by the owner can expire; a byte waiting in SEND never does.
  assign expire  = (state_q == ST_LOCK) && !sel_valid && (cnt_q == CNT_LAST);
  assign timeout = timeout_q;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q != ST_LOCK) begin
      // Held at zero outside LOCK so every entry into LOCK starts a fresh count.
      cnt_d = '0;
    end else if (expire) begin
      cnt_d     = '0;
      timeout_d = 1'b1;
    end else if (!sel_valid) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    last_d     = last_q;
    req_ready  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = arb_gnt;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        req_ready = req_valid & grant;
        if (sel_valid) begin
          tx_data_d  = sel_data;
          tx_valid_d = 1'b1;
          last_d     = sel_last;
          state_d    = ST_SEND;
        end else if (expire) begin
          ptr_d   = ptr_inc;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (tx_valid && tx_ready) begin
          tx_valid_d = 1'b0;
          if (last_q) begin
            ptr_d   = ptr_inc;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOCK;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant    <= '0;
      ptr_q    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      last_q   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      ptr_q    <= ptr_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      last_q   <= last_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues feed the DUT, expected bytes go to a scoreboard.
// Latency: n/a.
// Backpressure: tx_ready is driven by a programmable delay model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              timeout;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic [7:0]      data;
    logic [NREQ-1:0] gnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] rq[NREQ][$];   // {last, data} per requester

  int checks      = 0;
  int failures    = 0;
  int ready_delay = 1;
  int rdy_wait    = 0;
  bit ready_block = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic [NREQ-1:0] g);
    exp_t e;
    e.data = d;
    e.gnt  = g;
    exp_q.push_back(e);
  endtask

  function automatic bit all_empty();
    bit r = 1'b1;
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drive_reqs();
    logic [8:0] h;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        h = rq[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i]        = h[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && all_empty()) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // Requester and uart_tx models. req_ready is sampled at the negedge so the
  // pop matches the byte the DUT takes on the following posedge.
  initial begin
    logic [NREQ-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      drive_reqs();
      if (tx_ready) begin
        tx_ready = 1'b0;
      end else if (tx_valid && !ready_block) begin
        if (rdy_wait >= ready_delay) begin
          tx_ready = 1'b1;
          rdy_wait = 0;
        end else begin
          rdy_wait++;
        end
      end
    end
  end

  // Scoreboard monitor: every transmitted byte must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (|req_ready) chk("req_ready_granted_only", 32'(req_ready), 32'(req_ready & grant));
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: actual=0x%0h grant=0x%0h required=none at %0t",
                     tx_data, grant, $time);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte_data", 32'(tx_data), 32'(e.data));
            chk("tx_byte_grant", 32'(grant), 32'(e.gnt));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit seen;
    int k;
    rst_n = 1'b0;

    // Test 2 stimulus is present before reset release: req0 and req2 both valid.
    rq[0].push_back({1'b0, 8'h10});
    rq[0].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b0, 8'h20});
    rq[2].push_back({1'b1, 8'h21});
    expect_byte(8'h10, 4'b0001);
    expect_byte(8'h11, 4'b0001);
    expect_byte(8'h20, 4'b0100);
    expect_byte(8'h21, 4'b0100);

    repeat (3) @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_req_valid_seen", 32'(req_valid), 32'b0101);
    rst_n = 1'b1;
    wait_idle("t2_idle", 200);
    chk("t2_grant_idle", 32'(grant), 32'd0);

    // Test 1: req0 three-byte packet, tx_ready two cycles after each byte. Pointer is 3.
    ready_delay = 2;
    rq[0].push_back({1'b0, 8'h41});
    rq[0].push_back({1'b0, 8'h42});
    rq[0].push_back({1'b1, 8'h43});
    expect_byte(8'h41, 4'b0001);
    expect_byte(8'h42, 4'b0001);
    expect_byte(8'h43, 4'b0001);
    wait_idle("t1_idle", 200);
    chk("t1_grant_idle", 32'(grant), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    chk("t1_tx_valid_idle", 32'(tx_valid), 32'd0);

    // Test 3: all four with two single-byte packets each; pointer is 1 after req0.
    ready_delay = 0;
    for (int i = 0; i < NREQ; i++) begin
      rq[i].push_back({1'b1, 8'h30 + 8'(16 * i)});
      rq[i].push_back({1'b1, 8'h31 + 8'(16 * i)});
    end
    expect_byte(8'h40, 4'b0010);
    expect_byte(8'h50, 4'b0100);
    expect_byte(8'h60, 4'b1000);
    expect_byte(8'h30, 4'b0001);
    expect_byte(8'h41, 4'b0010);
    expect_byte(8'h51, 4'b0100);
    expect_byte(8'h61, 4'b1000);
    expect_byte(8'h31, 4'b0001);
    wait_idle("t3_idle", 200);

    // Test 4: req1 mid-packet with tx_ready held low; req0/req3 waiting must be ignored.
    ready_block = 1;
    rq[1].push_back({1'b0, 8'h51});
    rq[1].push_back({1'b1, 8'h52});
    rq[0].push_back({1'b1, 8'h70});
    rq[3].push_back({1'b1, 8'h73});
    expect_byte(8'h51, 4'b0010);
    expect_byte(8'h52, 4'b0010);
    expect_byte(8'h73, 4'b1000);
    expect_byte(8'h70, 4'b0001);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (tx_valid) found = 1'b1;
    end
    chk("t4_tx_valid_up", 32'(found), 32'd1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("t4_stall_tx_valid", 32'(tx_valid), 32'd1);
      chk("t4_stall_tx_data", 32'(tx_data), 32'h51);
      chk("t4_stall_req_ready", 32'(req_ready), 32'd0);
      chk("t4_stall_grant", 32'(grant), 32'b0010);
    end
    ready_block = 0;
    ready_delay = 1;
    wait_idle("t4_idle", 200);

    // Test 5: reset while req2 holds a byte in SEND. Pointer is 1, only req2 requests.
    ready_block = 1;
    rq[2].push_back({1'b0, 8'hA0});
    rq[2].push_back({1'b1, 8'hA1});
    expect_byte(8'hA0, 4'b0100);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (tx_valid) found = 1'b1;
    end
    chk("t5_tx_valid_up", 32'(found), 32'd1);
    rq[0].push_back({1'b1, 8'h90});
    repeat (3) @(negedge clk);
    chk("t5_locked_grant", 32'(grant), 32'b0100);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
    // The held byte is dropped; req2 re-presents a fresh packet.
    exp_q.delete();
    rq[2].delete();
    rq[2].push_back({1'b1, 8'hA2});
    expect_byte(8'h90, 4'b0001);
    expect_byte(8'hA2, 4'b0100);
    ready_block = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("t5_idle", 200);

    // Test 6: req3 sends a non-last byte then goes quiet. Pointer is 3.
    ready_delay = 1;
    rq[3].push_back({1'b0, 8'hB0});
    expect_byte(8'hB0, 4'b1000);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) found = 1'b1;
    end
    chk("t6_handshake", 32'(found), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
    seen = 1'b0;
    k    = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (timeout) begin
        seen = 1'b1;
        k    = c;
      end
    end
    chk("t6_timeout_delay", 32'(k), 32'd17);
    chk("t6_timeout_grant", 32'(grant), 32'd0);
    chk("t6_timeout_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t6_timeout_pulse_end", 32'(timeout), 32'd0);
    rq[1].push_back({1'b1, 8'hC0});
    expect_byte(8'hC0, 4'b0010);
    wait_idle("t6_after_timeout_idle", 200);
`else
    seen = 1'b0;
    k    = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (timeout) seen = 1'b1;
      if (grant == 4'b1000) k++;
    end
    chk("t6_no_timeout", 32'(seen), 32'd0);
    chk("t6_lock_cycles", 32'(k), 32'd40);
    chk("t6_lock_busy", 32'(busy), 32'd1);
    rq[3].push_back({1'b1, 8'hB1});
    expect_byte(8'hB1, 4'b1000);
    wait_idle("t6_lock_idle", 200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
